fp4_mac_array: RTL and testbench



---
 rtl/fp4_pkg.sv | 50 +++++
 rtl/fp4_lane.sv | 93 +++++++++
 rtl/fp4_mac_array.sv | 96 +++++++++
 tb/tb_fp4_mac_array.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp4_pkg.sv
// Shared FP4 (E2M1) definitions: field layout, code constants, quarter-unit grid
// and the decode/round helpers used by every MAC lane.
package fp4_pkg;

    localparam int FP4_W      = 4;
    localparam int FP4_SIGN   = 3;
    localparam int FP4_EXP_HI = 2;
    localparam int FP4_EXP_LO = 1;
    localparam int FP4_MAN    = 0;

    typedef logic [FP4_W-1:0] fp4_t;

    localparam fp4_t FP4_ZERO = 4'h0;
    localparam fp4_t FP4_MAX  = 4'h7;

    // Representable magnitudes expressed in quarter units (LSB = 0.25)
    localparam int Q_0P0 = 0;
    localparam int Q_0P5 = 2;
    localparam int Q_1P0 = 4;
    localparam int Q_1P5 = 6;
    localparam int Q_2P0 = 8;
    localparam int Q_3P0 = 12;
    localparam int Q_4P0 = 16;
    localparam int Q_6P0 = 24;

    function automatic logic [3:0] fp4_mag2(input fp4_t c);
        logic [1:0] e;
        logic [3:0] base;
        e    = c[FP4_EXP_HI:FP4_EXP_LO];
        base = {2'b00, 1'b1, c[FP4_MAN]};
        if (e == 2'd0) begin
            return {3'b000, c[FP4_MAN]};
        end
        return base << (e - 2'd1);
    endfunction

    // Midpoints between grid neighbours; '<=' where the lower neighbour has an
    // even mantissa (ties round down), '<' where the upper one does.
    function automatic logic [2:0] fp4_round_q(input logic [31:0] q);
        if (q <= 32'((Q_0P0 + Q_0P5) / 2)) return 3'd0;
        if (q <  32'((Q_0P5 + Q_1P0) / 2)) return 3'd1;
        if (q <= 32'((Q_1P0 + Q_1P5) / 2)) return 3'd2;
        if (q <  32'((Q_1P5 + Q_2P0) / 2)) return 3'd3;
        if (q <= 32'((Q_2P0 + Q_3P0) / 2)) return 3'd4;
        if (q <  32'((Q_3P0 + Q_4P0) / 2)) return 3'd5;
        if (q <= 32'((Q_4P0 + Q_6P0) / 2)) return 3'd6;
        return FP4_MAX[2:0];
    endfunction

endpackage

// File: rtl/fp4_lane.sv
// One FP4 MAC lane: product register, exact saturating accumulator, and a
// round-to-FP4 result register loaded when the final sum is ready.
module fp4_lane
    import fp4_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic acc_en,
    input  logic fin,
    input  fp4_t a,
    input  fp4_t b,
    output fp4_t res,
    output logic sat
);

    localparam int SUM_W   = ACC_W + 1;
    localparam int ACC_MAX = (2 ** (ACC_W - 1)) - 1;
    localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(ACC_MAX);
    localparam logic signed [SUM_W-1:0] SUM_LO = -SUM_HI;

    logic        [7:0]       prod_mag;
    logic signed [8:0]       prod_next;
    logic signed [8:0]       prod_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SUM_W-1:0] sum;
    logic                    ovf;
    logic                    sticky;
    logic        [ACC_W-1:0] acc_abs;
    logic        [2:0]       mag_code;
    fp4_t                    rnd_code;

    always_comb begin
        prod_mag  = 8'(fp4_mag2(a)) * 8'(fp4_mag2(b));
        prod_next = (a[FP4_SIGN] ^ b[FP4_SIGN]) ? -$signed({1'b0, prod_mag})
                                                :  $signed({1'b0, prod_mag});
    end

    always_comb begin
        sum      = SUM_W'(acc) + SUM_W'(prod_q);
        ovf      = 1'b1;
        acc_next = '0;
        if (sum > SUM_HI) begin
            acc_next = ACC_W'(SUM_HI);
        end else if (sum < SUM_LO) begin
            acc_next = ACC_W'(SUM_LO);
        end else begin
            acc_next = sum[ACC_W-1:0];
            ovf      = 1'b0;
        end
    end

    // Clamping keeps |acc| <= ACC_MAX, so negation here can never overflow.
    always_comb begin
        acc_abs  = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
        mag_code = fp4_round_q(32'(acc_abs));
        rnd_code = (mag_code == 3'd0) ? FP4_ZERO : {acc[ACC_W-1], mag_code};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            res    <= FP4_ZERO;
            sat    <= 1'b0;
        end else if (clr) begin
            prod_q <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            res    <= FP4_ZERO;
            sat    <= 1'b0;
        end else begin
            if (load) begin
                prod_q <= prod_next;
            end
            if (fin) begin
                res    <= rnd_code;
                sat    <= sticky;
                acc    <= '0;
                sticky <= 1'b0;
            end else if (acc_en) begin
                acc    <= acc_next;
                sticky <= sticky | ovf;
            end
        end
    end

endmodule

// File: rtl/fp4_mac_array.sv
// Multi-lane FP4 MAC engine: beat acceptance, the valid pipeline that follows
// the last beat through the lanes, and the held valid/ready result register.
module fp4_mac_array
    import fp4_pkg::*;
#(
    parameter int LANES = 4,
    parameter int ACC_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [FP4_W*LANES-1:0] in_a,
    input  logic [FP4_W*LANES-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP4_W*LANES-1:0] out_res,
    output logic [LANES-1:0]       out_sat
);

    logic                   accept;
    logic                   s1_valid;
    logic                   s1_last;
    logic                   s2_last;
    logic                   s3_valid;
    logic [FP4_W*LANES-1:0] lane_res;
    logic [LANES-1:0]       lane_sat;

    assign accept = in_valid & in_ready & ~clr;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fp4_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .load   (accept),
            .acc_en (s1_valid),
            .fin    (s2_last),
            .a      (in_a[FP4_W*i +: FP4_W]),
            .b      (in_b[FP4_W*i +: FP4_W]),
            .res    (lane_res[FP4_W*i +: FP4_W]),
            .sat    (lane_sat[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
            s3_valid <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept & in_last;
            s2_last  <= s1_valid & s1_last;
            s3_valid <= s2_last;
        end
    end

    // Only one vector is ever in flight after its last beat, so loading the
    // output register never collides with a pending handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_sat   <= '0;
        end else if (clr) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (accept && in_last) begin
                in_ready <= 1'b0;
            end else if (out_valid && out_ready) begin
                in_ready <= 1'b1;
            end
            if (s3_valid) begin
                out_valid <= 1'b1;
                out_res   <= lane_res;
                out_sat   <= lane_sat;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp4_mac_array.sv
// Directed bench for fp4_mac_array (4 lanes, 9-bit accumulator) with a
// reference model feeding a scoreboard of expected results.
module tb_fp4_mac_array;

    localparam int LANES = 4;
    localparam int ACC_W = 9;
    localparam int LIM   = (2 ** (ACC_W - 1)) - 1;

    typedef struct {
        logic [4*LANES-1:0] res;
        logic [LANES-1:0]   sat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_last = 1'b0;
    logic [4*LANES-1:0] in_a = '0;
    logic [4*LANES-1:0] in_b = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [4*LANES-1:0] out_res;
    logic [LANES-1:0]   out_sat;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   macc[LANES];
    bit   msat[LANES];

    fp4_mac_array #(
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mag2(input logic [3:0] c);
        int tab[8] = '{0, 1, 2, 3, 4, 6, 8, 12};
        return tab[c[2:0]];
    endfunction

    // Nearest grid point by distance, ties to the even code.
    function automatic logic [3:0] model_round(input int v);
        int grid[8] = '{0, 2, 4, 6, 8, 12, 16, 24};
        int q, d, best, bestd;
        q     = (v < 0) ? -v : v;
        best  = 0;
        bestd = 1 << 30;
        for (int c = 0; c < 8; c++) begin
            d = (q > grid[c]) ? q - grid[c] : grid[c] - q;
            if (d < bestd || (d == bestd && (c % 2) == 0)) begin
                best  = c;
                bestd = d;
            end
        end
        return (v < 0 && best != 0) ? 4'(8 + best) : 4'(best);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            macc[l] = 0;
            msat[l] = 1'b0;
        end
    endtask

    task automatic model_beat(input logic [4*LANES-1:0] a, input logic [4*LANES-1:0] b, input logic last);
        exp_t e;
        int   p;
        logic [3:0] ca, cb;
        for (int l = 0; l < LANES; l++) begin
            ca = a[4*l +: 4];
            cb = b[4*l +: 4];
            p  = mag2(ca) * mag2(cb);
            if (ca[3] ^ cb[3]) p = -p;
            macc[l] += p;
            if (macc[l] > LIM) begin
                macc[l] = LIM;
                msat[l] = 1'b1;
            end else if (macc[l] < -LIM) begin
                macc[l] = -LIM;
                msat[l] = 1'b1;
            end
        end
        if (last) begin
            for (int l = 0; l < LANES; l++) begin
                e.res[4*l +: 4] = model_round(macc[l]);
                e.sat[l]        = msat[l];
            end
            sb.push_back(e);
            model_reset();
        end
    endtask

    task automatic apply_stimulus(input logic [4*LANES-1:0] a, input logic [4*LANES-1:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        check("in_ready_beat", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        model_beat(a, b, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_output();
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("in_ready_low", 32'(in_ready), 32'd0);
        end while (!out_valid && n < 20);
        check("latency", 32'(n), 32'd3);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("out_res", 32'(out_res), 32'(e.res));
            check("out_sat", 32'(out_sat), 32'(e.sat));
        end
    endtask

    task automatic drain_output();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [4*LANES-1:0] held;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] mixed-lane three-beat vector");
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        apply_stimulus(16'hC002, 16'h2002, 1'b0);
        apply_stimulus(16'h5132, 16'h2132, 1'b1);
        check_output();
        drain_output();

        $display("[TB] negative sums and -0 operand");
        apply_stimulus(16'h2000, 16'h2000, 1'b0);
        apply_stimulus(16'hCF80, 16'h2170, 1'b1);
        check_output();
        drain_output();

        $display("[TB] accumulator saturation with output stall");
        apply_stimulus(16'h00F7, 16'h0077, 1'b0);
        apply_stimulus(16'h00F7, 16'h0077, 1'b1);
        check_output();
        held     = out_res;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = 16'h7777;
        in_b     = 16'h7777;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_res", 32'(out_res), 32'(held));
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain_output();

        $display("[TB] sticky flag restarts on next vector");
        apply_stimulus(16'h0002, 16'h0002, 1'b1);
        check_output();
        drain_output();

        $display("[TB] clr mid-vector");
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_a     = 16'h0007;
        in_b     = 16'h0007;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_reset();
        check("clr_in_ready", 32'(in_ready), 32'd1);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        expect_idle("clr_no_result", 6);
        apply_stimulus(16'h0002, 16'h0002, 1'b1);
        check_output();
        drain_output();

        $display("[TB] rst mid-vector");
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        apply_stimulus(16'h0002, 16'h0002, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        expect_idle("rst_no_result", 6);
        apply_stimulus(16'h0002, 16'h0002, 1'b1);
        check_output();

        $display("[TB] rst during output stall");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        check("rst_stall_res", 32'(out_res), 32'd0);
        check("rst_stall_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        apply_stimulus(16'h0002, 16'h0002, 1'b1);
        check_output();
        drain_output();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
